// File: rtl/api_initiator.sv
// Single-outstanding bus initiator: a valid/ready command becomes one cs/we access on the
// register API, and the result (or a timeout) comes back on a valid/ready response.
module api_initiator #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_address,
  input  logic [31:0] req_write_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_read_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        cs,
  output logic        we,
  output logic [7:0]  address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  input  logic        ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_reg;
  state_t            state_next;
  logic              we_reg;
  logic [7:0]        addr_reg;
  logic [31:0]       wdata_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [31:0]       rdata_reg;
  logic              timeout_reg;

  logic              accept;
  logic              in_access;
  logic              hit_last;

  assign accept    = (state_reg == IDLE) && req_valid;
  assign in_access = (state_reg == ACCESS);
  assign hit_last  = (cnt_reg == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a ready in the last allowed cycle still completes normally
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (ready || hit_last) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; API strobes come only from state and latched command registers
  always_comb begin
    req_ready = 1'b0;
    cs        = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = reset_n;
      end
      ACCESS: begin
        cs   = 1'b1;
        busy = 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
    we            = cs & we_reg;
    address       = addr_reg;
    write_data    = wdata_reg;
    rsp_read_data = rdata_reg;
    rsp_timeout   = timeout_reg;
  end

  // Command latch; holds its value outside ACCESS so the API bus stays quiet
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_reg    <= 1'b0;
      addr_reg  <= 8'd0;
      wdata_reg <= 32'd0;
    end else if (accept) begin
      we_reg    <= req_we;
      addr_reg  <= req_address;
      wdata_reg <= req_write_data;
    end
  end

  // Wait-cycle counter for the timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
    end else if (in_access && !ready) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Response capture; writes and aborted accesses report zero data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_reg   <= 32'd0;
      timeout_reg <= 1'b0;
    end else if (in_access) begin
      if (ready) begin
        rdata_reg   <= we_reg ? 32'd0 : read_data;
        timeout_reg <= 1'b0;
      end else if (hit_last) begin
        rdata_reg   <= 32'd0;
        timeout_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_api_initiator.sv
module tb_api_initiator;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_address;
    logic [31:0] req_write_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_read_data;
    logic        rsp_timeout;
    logic        busy;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    int          n_checks = 0;
    int          n_errors = 0;
    int          tgt_wait = NEVER;
    logic [31:0] tgt_rdata = 32'd0;
    int          cs_cnt = 0;

    api_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_address(req_address), .req_write_data(req_write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_read_data(rsp_read_data), .rsp_timeout(rsp_timeout), .busy(busy),
        .cs(cs), .we(we), .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ready     = cs && (cs_cnt == tgt_wait);
    assign read_data = tgt_rdata;
    always @(posedge clk) cs_cnt <= cs ? cs_cnt + 1 : 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_req(input bit keep_valid);
        req_valid      = keep_valid;
        req_we         = 1'($urandom);
        req_address    = 8'($urandom);
        req_write_data = $urandom;
    endtask

    task automatic run_txn(input logic t_we, input logic [7:0] t_addr, input logic [31:0] t_wdata,
                           input logic [31:0] t_rdata, input int t_wait, input int t_rsp_delay,
                           input bit t_hold_valid);
        bit          exp_to;
        int          exp_cs;
        logic [31:0] exp_rd;
        int          cycles;
        int          cs_seen;
        exp_to = (t_wait >= TIMEOUT);
        exp_cs = exp_to ? TIMEOUT : t_wait + 1;
        exp_rd = (exp_to || t_we) ? 32'd0 : t_rdata;
        tgt_wait  = t_wait;
        tgt_rdata = t_rdata;
        req_valid      = 1'b1;
        req_we         = t_we;
        req_address    = t_addr;
        req_write_data = t_wdata;
        check("accept_req_ready", req_ready, 1'b1);
        cycles  = 0;
        cs_seen = 0;
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            @(posedge clk); #1;
            cycles++;
            scramble_req(t_hold_valid);
            if (rsp_valid) break;
            if (cs) begin
                cs_seen++;
                check("api_we", we, t_we);
                check("api_address", address, t_addr);
                check("api_write_data", write_data, t_wdata);
            end else begin
                check("we_without_cs", we, 1'b0);
            end
        end
        check("rsp_valid_seen", rsp_valid, 1'b1);
        check("cs_cycles", cs_seen, exp_cs);
        check("rsp_latency", cycles, exp_cs + 1);
        check("rsp_timeout", rsp_timeout, exp_to);
        check("rsp_read_data", rsp_read_data, exp_rd);
        check("resp_busy", busy, 1'b1);
        check("resp_req_ready", req_ready, 1'b0);
        for (int d = 0; d < t_rsp_delay; d++) begin
            @(posedge clk); #1;
            scramble_req(t_hold_valid);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_read_data", rsp_read_data, exp_rd);
            check("hold_rsp_timeout", rsp_timeout, exp_to);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_cs", cs, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("post_rsp_valid", rsp_valid, 1'b0);
        check("post_req_ready", req_ready, 1'b1);
        check("post_busy", busy, 1'b0);
        $display("txn we=%0b addr=%02h wdata=%08h wait=%0d delay=%0d -> cs=%0d timeout=%0b rdata=%08h",
                 t_we, t_addr, t_wdata, t_wait, t_rsp_delay, cs_seen, rsp_timeout, rsp_read_data);
    endtask

    initial begin
        int w;
        int r;
        reset_n        = 1'b0;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_address    = 8'd0;
        req_write_data = 32'd0;
        rsp_ready      = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_cs", cs, 1'b0);
        check("rst_we", we, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("init_req_ready", req_ready, 1'b1);
        check("init_address", address, 8'h00);
        check("init_write_data", write_data, 32'h0);
        check("init_rsp_read_data", rsp_read_data, 32'h0);
        check("init_rsp_timeout", rsp_timeout, 1'b0);

        run_txn(1'b1, 8'h0a, 32'h0000_1234, 32'hdead_beef, 0, 0, 1'b0);
        run_txn(1'b0, 8'h09, 32'h0000_5555, 32'h0000_0001, 0, 1, 1'b0);
        run_txn(1'b0, 8'h33, 32'h0, 32'h0000_ffff, NEVER, 0, 1'b0);
        run_txn(1'b0, 8'h44, 32'h0, 32'hcafe_f00d, TIMEOUT - 1, 0, 1'b0);
        run_txn(1'b1, 8'h55, 32'h0000_abcd, 32'h1111_2222, 2, 10, 1'b1);
        run_txn(1'b0, 8'h56, 32'h0, 32'h8765_4321, 1, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)      w = int'($urandom_range(0, 3));
            else if (r < 8) w = int'($urandom_range(4, TIMEOUT + 1));
            else            w = NEVER;
            run_txn(1'($urandom), 8'($urandom), $urandom, $urandom, w,
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        tgt_wait       = NEVER;
        req_valid      = 1'b1;
        req_we         = 1'b1;
        req_address    = 8'h77;
        req_write_data = 32'h0bad_0bad;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("mid_access_cs", cs, 1'b1);
        check("mid_access_we", we, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_cs", cs, 1'b0);
        check("async_rst_we", we, 1'b0);
        check("async_rst_rsp_valid", rsp_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("post_rst_req_ready", req_ready, 1'b1);
            check("post_rst_cs", cs, 1'b0);
            check("post_rst_rsp_valid", rsp_valid, 1'b0);
        end
        $display("reset during access: cs=%0b busy=%0b req_ready=%0b", cs, busy, req_ready);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
